eka_mem_arbiter: RTL and testbench
==================================

Name: eka_mem_arbiter

Overview:
- Sequencer and arbiter that lets the single-cycle Eka core share one memory port for instruction fetch and data load/store.
- Fetches each instruction into a holding register and presents it with inst_valid. If the instruction accesses memory, it holds the core with data_stall, runs the data transaction, then releases the core for one commit cycle.
- Sits between the core's inst/data ports and a single req/ack memory bus (BRAM controller or bus bridge).

Parameters:
- ADDR_WIDTH, 32, width of inst_addr and bus_addr.
- NOP_INSTR, 32'h0000_0013, value driven on instruction when no valid fetch is held (addi x0,x0,0).
- TIMEOUT_CYCLES, 255, bus-ack watchdog limit; used only with the optional feature.

Ports:
- clk  in  1  processor clock
- reset  in  1  synchronous, active-high reset
- inst_addr  in  ADDR_WIDTH  core fetch address, word aligned
- data_addr  in  32  core load/store address
- mem_wr_data  in  32  core store data, already lane-replicated
- mem_wr_mask  in  4  core byte enables
- mem_wr  in  1  core store request (combinational from instruction)
- mem_rd  in  1  core load request (combinational from instruction)
- instruction  out  32  held instruction to core
- mem_rd_data  out  32  held load data to core
- inst_valid  out  1  instruction is valid this cycle
- data_stall  out  1  core must hold while data access is pending
- bus_req  out  1  memory request
- bus_addr  out  ADDR_WIDTH  memory address
- bus_wr  out  1  1 = write, 0 = read
- bus_wr_mask  out  4  byte enables (4'b1111 on reads)
- bus_wr_data  out  32  write data
- bus_ack  in  1  transaction complete; bus_rd_data valid this cycle
- bus_rd_data  in  32  read data
- bus_error  out  1  sticky watchdog error (tied 0 without the optional feature)

Behaviour:
- States: FETCH, EXEC, DATA, COMMIT. Registered outputs: state, instr_q, rdata_q. bus_* and handshake outputs are combinational from state.
- Reset (reset high at posedge): state=FETCH, instr_q=NOP_INSTR, rdata_q=0, bus_error=0. While reset is high: bus_req=0, inst_valid=0, data_stall=0. Reset mid-transaction abandons the transaction; no bus_req in the cycle after reset.
- FETCH:
  - bus_req=1, bus_addr=inst_addr, bus_wr=0, bus_wr_mask=4'b1111.
  - inst_valid=0, data_stall=0, instruction=instr_q.
  - On bus_ack: instr_q<=bus_rd_data, go to EXEC. The ack may arrive in the first req cycle; minimum fetch is 1 cycle.
- EXEC:
  - instruction=instr_q, inst_valid=1.
  - If mem_rd|mem_wr: data_stall=1, bus_req=1, bus_addr=data_addr, bus_wr=mem_wr, bus_wr_mask=mem_wr?mem_wr_mask:4'b1111, bus_wr_data=mem_wr_data.
    - On bus_ack: rdata_q<=bus_rd_data, go to COMMIT.
    - Without ack: go to DATA.
  - Otherwise: data_stall=0, bus_req=0. This is the commit cycle; the core advances PC. Go to FETCH.
- DATA: same bus drive as EXEC with a memory op, data_stall=1. On bus_ack: latch rdata_q, go to COMMIT.
- COMMIT:
  - inst_valid=1, data_stall=0, mem_rd_data=rdata_q, bus_req=0.
  - The store is not reissued even though the core still asserts mem_wr.
  - Go to FETCH.
- Throughput:
  - Non-memory instruction: fetch latency + 1 cycle.
  - Load/store: fetch latency + data latency + 1 cycle.
- Bus rules:
  - bus_addr, bus_wr, bus_wr_mask and bus_wr_data are stable while bus_req=1 and bus_ack=0.
  - bus_ack with bus_req=0 is ignored.
  - Exactly one ack is consumed per request.
- mem_rd and mem_wr both high: treated as a write.
- mem_rd_data equals rdata_q in every state.
- instr_q holds its value until the next fetch ack.

Optional Feature:
- Macro: EKA_MEM_ARB_TIMEOUT_EN.
- Defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) counts cycles with bus_req=1 and no ack. It clears on each new request.
  - On reaching TIMEOUT_CYCLES without ack, the transaction aborts: bus_req=0 next cycle and bus_error<=1 (sticky until reset).
  - Fetch timeout: instr_q<=NOP_INSTR, go to EXEC.
  - Data timeout: rdata_q<=0, go to COMMIT.
- Not defined: no counter, bus_error tied 0, arbiter waits indefinitely for ack.

Test Plan:
- Reset, then memory acks every request in 1 cycle with addi at 0x0 -> FETCH at 0x0 for 1 cycle, EXEC with inst_valid=1 and data_stall=0; next fetch at 0x4. Two cycles per instruction.
- lw at 0x8, data_addr=0x100, memory returns 0xDEADBEEF with 3-cycle latency -> EXEC/DATA hold data_stall=1 with bus_addr=0x100 and bus_wr=0; COMMIT has mem_rd_data=0xDEADBEEF, inst_valid=1, data_stall=0.
- sb to 0x103 with mem_wr_mask=4'b1000 -> exactly one bus write, bus_wr_mask=4'b1000; no bus_req in COMMIT.
- Ack withheld 5 cycles during fetch with inst_addr toggled by the bench -> bus_addr stays at the latched-cycle value; instruction stays at the previous instr_q until the ack.
- reset asserted in DATA mid-load -> next cycle bus_req=0, inst_valid=0, state FETCH; rdata_q=0.
- With EKA_MEM_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=4, no ack on fetch -> bus_req drops after 4 cycles, bus_error=1 and stays 1, instruction=0x00000013 in EXEC.

Source files
------------

// File: rtl/eka_mem_arbiter.sv
// Fetch/data sequencer sharing one req/ack memory port for the Eka core; optional ack watchdog under EKA_MEM_ARB_TIMEOUT_EN.
// Latency: fetch ack + 1 commit cycle (+ data ack for loads/stores); stalls indefinitely on a missing ack unless the watchdog is built in.
module eka_mem_arbiter #(
    parameter int          ADDR_WIDTH     = 32,
    parameter logic [31:0] NOP_INSTR      = 32'h0000_0013,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] inst_addr,
    input  logic [31:0]           data_addr,
    input  logic [31:0]           mem_wr_data,
    input  logic [3:0]            mem_wr_mask,
    input  logic                  mem_wr,
    input  logic                  mem_rd,
    output logic [31:0]           instruction,
    output logic [31:0]           mem_rd_data,
    output logic                  inst_valid,
    output logic                  data_stall,
    output logic                  bus_req,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic                  bus_wr,
    output logic [3:0]            bus_wr_mask,
    output logic [31:0]           bus_wr_data,
    input  logic                  bus_ack,
    input  logic [31:0]           bus_rd_data,
    output logic                  bus_error
);

    typedef enum logic [1:0] {FETCH, EXEC, DATA, COMMIT} state_t;

    state_t                state, state_nxt;
    logic [31:0]           instr_q, rdata_q;
    logic                  hold;
    logic [ADDR_WIDTH-1:0] addr_q, addr_c;
    logic                  wr_q, wr_c;
    logic [3:0]            mask_q, mask_c;
    logic [31:0]           wdata_q;
    logic                  mem_op, req_c, valid_c, stall_c, ack, tmo;

    assign mem_op = mem_rd | mem_wr;
    assign req_c  = (state == FETCH) || (state == DATA) || (state == EXEC && mem_op);
    assign ack    = bus_req & bus_ack;

    assign addr_c = (state == FETCH) ? inst_addr : ADDR_WIDTH'(data_addr);
    assign wr_c   = (state != FETCH) & mem_wr;
    assign mask_c = wr_c ? mem_wr_mask : 4'b1111;

    // 'hold' marks the cycles after the first of a request: replay the latched
    // command so the bus sees it stable even if the core's inputs wander.
    assign bus_req     = req_c & ~reset;
    assign bus_addr    = hold ? addr_q  : addr_c;
    assign bus_wr      = hold ? wr_q    : wr_c;
    assign bus_wr_mask = hold ? mask_q  : mask_c;
    assign bus_wr_data = hold ? wdata_q : mem_wr_data;

    assign inst_valid  = valid_c & ~reset;
    assign data_stall  = stall_c & ~reset;
    assign instruction = instr_q;
    assign mem_rd_data = rdata_q;

    always_comb begin
        state_nxt = state;
        valid_c   = 1'b0;
        stall_c   = 1'b0;
        case (state)
            FETCH: begin
                if (ack || tmo) state_nxt = EXEC;
            end
            EXEC: begin
                valid_c = 1'b1;
                if (mem_op) begin
                    stall_c   = 1'b1;
                    state_nxt = (ack || tmo) ? COMMIT : DATA;
                end else begin
                    state_nxt = FETCH;
                end
            end
            DATA: begin
                valid_c = 1'b1;
                stall_c = 1'b1;
                if (ack || tmo) state_nxt = COMMIT;
            end
            COMMIT: begin
                valid_c   = 1'b1;
                state_nxt = FETCH;
            end
            default: state_nxt = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= FETCH;
            instr_q <= NOP_INSTR;
            rdata_q <= '0;
            hold    <= 1'b0;
            addr_q  <= '0;
            wr_q    <= 1'b0;
            mask_q  <= 4'b1111;
            wdata_q <= '0;
        end else begin
            state <= state_nxt;
            hold  <= bus_req & ~bus_ack & ~tmo;
            if (!hold) begin
                addr_q  <= addr_c;
                wr_q    <= wr_c;
                mask_q  <= mask_c;
                wdata_q <= mem_wr_data;
            end
            if (state == FETCH) begin
                if (ack)      instr_q <= bus_rd_data;
                else if (tmo) instr_q <= NOP_INSTR;
            end else if (bus_req) begin
                if (ack)      rdata_q <= bus_rd_data;
                else if (tmo) rdata_q <= '0;
            end
        end
    end

`ifdef EKA_MEM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt, cnt_cur;
    logic             err_q;

    // Count restarts from zero on the first cycle of every new request.
    assign cnt_cur   = hold ? cnt : '0;
    assign tmo       = bus_req & ~bus_ack & (cnt_cur == CNT_W'(TIMEOUT_CYCLES - 1));
    assign bus_error = err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= '0;
            err_q <= 1'b0;
        end else begin
            if (bus_req && !bus_ack && !tmo) cnt <= cnt_cur + CNT_W'(1);
            else                             cnt <= '0;
            if (tmo) err_q <= 1'b1;
        end
    end
`else
    assign tmo       = 1'b0;
    assign bus_error = 1'b0;
`endif

endmodule

// File: tb/tb_eka_mem_arbiter.sv
// Directed-vector bench for eka_mem_arbiter; the bench plays the memory by hand, cycle by cycle.
module tb_eka_mem_arbiter;

    localparam int TMO = 4;
`ifdef EKA_MEM_ARB_TIMEOUT_EN
    localparam int STALL_N = 2;
`else
    localparam int STALL_N = 4;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] inst_addr, data_addr, mem_wr_data;
    logic [3:0]  mem_wr_mask;
    logic        mem_wr, mem_rd;
    logic [31:0] instruction, mem_rd_data;
    logic        inst_valid, data_stall, bus_req, bus_wr, bus_ack, bus_error;
    logic [31:0] bus_addr, bus_wr_data, bus_rd_data;
    logic [3:0]  bus_wr_mask;

    int n_vec = 0;
    int n_err = 0;
    int n_wr  = 0;
    int wr0   = 0;

    always #5 clk = ~clk;

    eka_mem_arbiter #(
        .ADDR_WIDTH     (32),
        .NOP_INSTR      (32'h0000_0013),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .inst_addr   (inst_addr),
        .data_addr   (data_addr),
        .mem_wr_data (mem_wr_data),
        .mem_wr_mask (mem_wr_mask),
        .mem_wr      (mem_wr),
        .mem_rd      (mem_rd),
        .instruction (instruction),
        .mem_rd_data (mem_rd_data),
        .inst_valid  (inst_valid),
        .data_stall  (data_stall),
        .bus_req     (bus_req),
        .bus_addr    (bus_addr),
        .bus_wr      (bus_wr),
        .bus_wr_mask (bus_wr_mask),
        .bus_wr_data (bus_wr_data),
        .bus_ack     (bus_ack),
        .bus_rd_data (bus_rd_data),
        .bus_error   (bus_error)
    );

    always @(posedge clk) begin
        if (bus_req === 1'b1 && bus_ack === 1'b1 && bus_wr === 1'b1) n_wr++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; inst_addr = '0; data_addr = '0; mem_wr_data = '0; mem_wr_mask = '0;
        mem_wr = 1'b0; mem_rd = 1'b0; bus_ack = 1'b0; bus_rd_data = '0;

        cyc();
        check("rst_req", bus_req, 1'b0);
        check("rst_vld", inst_valid, 1'b0);
        check("rst_stall", data_stall, 1'b0);
        cyc();
        check("rst_instr", instruction, 32'h0000_0013);
        check("rst_rdata", mem_rd_data, 32'h0);
        check("rst_err", bus_error, 1'b0);

        // single-cycle acks, non-memory instructions
        cyc(); reset = 1'b0; inst_addr = 32'h0; bus_ack = 1'b1; bus_rd_data = 32'h0000_0093; #1;
        check("f0_req", bus_req, 1'b1);
        check("f0_addr", bus_addr, 32'h0);
        check("f0_wr", bus_wr, 1'b0);
        check("f0_mask", bus_wr_mask, 4'b1111);
        check("f0_vld", inst_valid, 1'b0);
        cyc(); bus_ack = 1'b0; bus_rd_data = '0; #1;
        check("e0_vld", inst_valid, 1'b1);
        check("e0_stall", data_stall, 1'b0);
        check("e0_req", bus_req, 1'b0);
        check("e0_instr", instruction, 32'h0000_0093);
        cyc(); inst_addr = 32'h4; bus_ack = 1'b1; bus_rd_data = 32'h0010_0113; #1;
        check("f4_req", bus_req, 1'b1);
        check("f4_addr", bus_addr, 32'h4);
        cyc(); bus_ack = 1'b0; #1;
        check("e4_instr", instruction, 32'h0010_0113);
        check("e4_vld", inst_valid, 1'b1);

        // lw with 3-cycle data latency
        cyc(); inst_addr = 32'h8; bus_ack = 1'b1; bus_rd_data = 32'h1000_2083; #1;
        check("f8_addr", bus_addr, 32'h8);
        cyc(); bus_ack = 1'b0; mem_rd = 1'b1; data_addr = 32'h100; #1;
        check("lw_e_stall", data_stall, 1'b1);
        check("lw_e_req", bus_req, 1'b1);
        check("lw_e_addr", bus_addr, 32'h100);
        check("lw_e_wr", bus_wr, 1'b0);
        check("lw_e_mask", bus_wr_mask, 4'b1111);
        check("lw_e_vld", inst_valid, 1'b1);
        cyc(); data_addr = 32'h999; #1;
        check("lw_d1_stall", data_stall, 1'b1);
        check("lw_d1_addr", bus_addr, 32'h100);
        cyc(); bus_ack = 1'b1; bus_rd_data = 32'hDEAD_BEEF; #1;
        check("lw_d2_req", bus_req, 1'b1);
        check("lw_d2_addr", bus_addr, 32'h100);
        check("lw_d2_wr", bus_wr, 1'b0);
        cyc(); bus_ack = 1'b0; bus_rd_data = '0; #1;
        check("lw_c_rdata", mem_rd_data, 32'hDEAD_BEEF);
        check("lw_c_vld", inst_valid, 1'b1);
        check("lw_c_stall", data_stall, 1'b0);
        check("lw_c_req", bus_req, 1'b0);
        cyc(); mem_rd = 1'b0; data_addr = '0; inst_addr = 32'hC; bus_ack = 1'b1; bus_rd_data = 32'h0000_00A3; #1;
        check("lw_f_rdata", mem_rd_data, 32'hDEAD_BEEF);
        check("lw_f_addr", bus_addr, 32'hC);

        // sb to 0x103, single write, no reissue in COMMIT
        wr0 = n_wr;
        cyc(); bus_ack = 1'b1; bus_rd_data = 32'h0BAD_F00D; mem_wr = 1'b1; data_addr = 32'h103;
        mem_wr_mask = 4'b1000; mem_wr_data = 32'hAAAA_AAAA; #1;
        check("sb_req", bus_req, 1'b1);
        check("sb_wr", bus_wr, 1'b1);
        check("sb_mask", bus_wr_mask, 4'b1000);
        check("sb_addr", bus_addr, 32'h103);
        check("sb_wdata", bus_wr_data, 32'hAAAA_AAAA);
        check("sb_stall", data_stall, 1'b1);
        cyc(); bus_ack = 1'b0; #1;
        check("sb_c_req", bus_req, 1'b0);
        check("sb_c_vld", inst_valid, 1'b1);
        check("sb_c_rdata", mem_rd_data, 32'h0BAD_F00D);
        cyc(); mem_wr = 1'b0; mem_wr_mask = '0; inst_addr = 32'h10; #1;
        check("sb_nwr", n_wr - wr0, 32'd1);
        check("fs_addr", bus_addr, 32'h10);
        check("fs_instr", instruction, 32'h0000_00A3);

        // fetch ack withheld while inst_addr moves
        for (int i = 0; i < STALL_N; i++) begin
            cyc(); inst_addr = 32'h50 + 32'(4 * i); #1;
            check("fs_hold_addr", bus_addr, 32'h10);
            check("fs_hold_instr", instruction, 32'h0000_00A3);
        end
        cyc(); bus_ack = 1'b1; bus_rd_data = 32'h0000_0033; inst_addr = 32'h60; #1;
        check("fs_ack_addr", bus_addr, 32'h10);
        cyc(); bus_rd_data = 32'hFFFF_FFFF; #1;
        check("fs_e_instr", instruction, 32'h0000_0033);
        check("fs_e_req", bus_req, 1'b0);
        cyc(); inst_addr = 32'h14; bus_ack = 1'b1; bus_rd_data = 32'h00C0_A023; #1;
        check("ign_req", bus_req, 1'b1);
        check("ign_instr", instruction, 32'h0000_0033);
        check("ign_rdata", mem_rd_data, 32'h0BAD_F00D);

        // mem_rd and mem_wr together behave as a write
        cyc(); mem_rd = 1'b1; mem_wr = 1'b1; mem_wr_mask = 4'b0011; data_addr = 32'h204;
        mem_wr_data = 32'h5555_5555; bus_rd_data = 32'h77; #1;
        check("rw_wr", bus_wr, 1'b1);
        check("rw_mask", bus_wr_mask, 4'b0011);
        check("rw_instr", instruction, 32'h00C0_A023);
        cyc(); bus_ack = 1'b0; #1;
        check("rw_c_req", bus_req, 1'b0);
        check("rw_c_rdata", mem_rd_data, 32'h77);

        // reset in the middle of a load
        cyc(); mem_rd = 1'b0; mem_wr = 1'b0; mem_wr_mask = '0; inst_addr = 32'h18;
        bus_ack = 1'b1; bus_rd_data = 32'h2000_2083; #1;
        cyc(); bus_ack = 1'b0; mem_rd = 1'b1; data_addr = 32'h300; #1;
        check("rl_e_stall", data_stall, 1'b1);
        cyc(); #1;
        check("rl_d_req", bus_req, 1'b1);
        reset = 1'b1; #1;
        check("rl_rst_req", bus_req, 1'b0);
        check("rl_rst_vld", inst_valid, 1'b0);
        check("rl_rst_stall", data_stall, 1'b0);
        cyc();
        check("rl_rdata", mem_rd_data, 32'h0);
        check("rl_instr", instruction, 32'h0000_0013);
        check("rl_req", bus_req, 1'b0);
        cyc(); reset = 1'b0; mem_rd = 1'b0; inst_addr = 32'h0; #1;
        check("rl_f_req", bus_req, 1'b1);
        check("rl_f_addr", bus_addr, 32'h0);
        check("rl_f_vld", inst_valid, 1'b0);
        check("rl_f_stall", data_stall, 1'b0);

`ifdef EKA_MEM_ARB_TIMEOUT_EN
        for (int i = 1; i < TMO; i++) begin
            cyc(); #1;
            check("tmo_req", bus_req, 1'b1);
        end
        cyc(); #1;
        check("tmo_drop", bus_req, 1'b0);
        check("tmo_err", bus_error, 1'b1);
        check("tmo_instr", instruction, 32'h0000_0013);
        check("tmo_vld", inst_valid, 1'b1);
        cyc(); cyc(); #1;
        check("tmo_sticky", bus_error, 1'b1);
`else
        for (int i = 0; i < 2 * TMO; i++) begin
            cyc(); #1;
            check("wait_req", bus_req, 1'b1);
            check("wait_err", bus_error, 1'b0);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
